// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ byte sources; launch one cycle after a request is seen in IDLE.
// Requests are taken only in IDLE; while busy the arbiter ignores ReqValid; the start watchdog returns to IDLE.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  output logic [NUM_REQ-1:0]            ReqAck,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [DATA_WIDTH-1:0]         TxData,
  output logic                          TxStart,
  input  logic                          TxBusy,
  output logic                          Timeout,
  output logic                          ArbBusy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d, gidx_q, gidx_d, sel_idx, ptr_next;
  logic                  sel_vld;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    sel_oh, grant_d, ack_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  tx_start_d, timeout_d, arb_busy_d;
  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First pending requester at or above ptr, wrapping to 0.
  always_comb begin
    int cand;
    cand    = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_vld && ReqValid[PTR_W'(cand)]) begin
        sel_vld = 1'b1;
        sel_idx = PTR_W'(cand);
      end
    end
  end

  assign sel_oh   = NUM_REQ'(1) << sel_idx;
  assign ptr_next = (gidx_q == LAST_IDX) ? '0 : gidx_q + PTR_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    cnt_d      = cnt_q;
    grant_d    = Grant;
    ack_d      = '0;
    tx_data_d  = TxData;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    arb_busy_d = ArbBusy;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d    = LAUNCH;
          gidx_d     = sel_idx;
          grant_d    = sel_oh;
          ack_d      = sel_oh;
          tx_data_d  = req_bytes[sel_idx];
          tx_start_d = 1'b1;
          arb_busy_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (TxBusy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never accepted the launch: abandon and move on.
          state_d    = IDLE;
          cnt_d      = '0;
          timeout_d  = 1'b1;
          ptr_d      = ptr_next;
          grant_d    = '0;
          arb_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!TxBusy) begin
          state_d    = IDLE;
          ptr_d      = ptr_next;
          grant_d    = '0;
          arb_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      Grant   <= '0;
      ReqAck  <= '0;
      TxData  <= '0;
      TxStart <= 1'b0;
      Timeout <= 1'b0;
      ArbBusy <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      Grant   <= grant_d;
      ReqAck  <= ack_d;
      TxData  <= tx_data_d;
      TxStart <= tx_start_d;
      Timeout <= timeout_d;
      ArbBusy <= arb_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected launches, a monitor pops them on TxStart.
module tb_uart_tx_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  ReqValid;
  logic [31:0] ReqData;
  logic [3:0]  ReqAck;
  logic [3:0]  Grant;
  logic [7:0]  TxData;
  logic        TxStart;
  logic        TxBusy;
  logic        Timeout;
  logic        ArbBusy;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqAck(ReqAck), .Grant(Grant), .TxData(TxData), .TxStart(TxStart),
    .TxBusy(TxBusy), .Timeout(Timeout), .ArbBusy(ArbBusy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   start_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   ack_cnt [4] = '{default: 0};
  int   tx_busy_len = 10;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.grant = g;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Transmitter model: busy for tx_busy_len cycles starting the cycle after TxStart.
  initial begin
    int busy_left;
    bit launch_prev;
    busy_left   = 0;
    launch_prev = 1'b0;
    TxBusy      = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset_n !== 1'b1) begin
        busy_left   = 0;
        launch_prev = 1'b0;
      end else begin
        if (launch_prev) busy_left = tx_busy_len;
        else if (busy_left > 0) busy_left--;
        launch_prev = TxStart;
      end
      TxBusy = (busy_left > 0);
    end
  end

  // Monitor: every launch must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1) begin
        for (int i = 0; i < 4; i++) if (ReqAck[i]) ack_cnt[i]++;
        if (TxStart === 1'b1) begin
          start_cyc.push_back(cyc);
          n_starts++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_start: got grant %0h data %0h, required no launch", Grant, TxData);
          end else begin
            e = exp_q.pop_front();
            chk("start_grant", 32'(Grant), 32'(e.grant));
            chk("start_ack", 32'(ReqAck), 32'(e.grant));
            chk("start_data", 32'(TxData), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(Grant), 0);
    chk({tag, "_ack"}, 32'(ReqAck), 0);
    chk({tag, "_txdata"}, 32'(TxData), 0);
    chk({tag, "_txstart"}, 32'(TxStart), 0);
    chk({tag, "_timeout"}, 32'(Timeout), 0);
    chk({tag, "_arbbusy"}, 32'(ArbBusy), 0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (ArbBusy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle_wait: got ArbBusy stuck, required return to idle", tag);
    end
  endtask

  // Hold a request pattern until nl launches have been seen, then release it.
  task automatic run_req(input string tag, input logic [3:0] v, input int nl);
    int  base;
    bit  ok;
    base     = n_starts;
    ok       = 1'b0;
    ReqValid = v;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (n_starts >= base + nl) begin
        ok = 1'b1;
        break;
      end
    end
    ReqValid = 4'b0000;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_launches: got %0d, required %0d", tag, n_starts - base, nl);
    end
    wait_idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish within bound");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0, base, rel;
    Reset_n  = 1'b0;
    ReqValid = 4'b0000;
    ReqData  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single request with a 10-cycle frame.
    tx_busy_len = 10;
    push(4'b0001, 8'hA5);
    n0 = cyc;
    ReqValid = 4'b0001;
    @(negedge Clk);
    chk("single_start_latency", 32'(TxStart), 1);
    chk("single_arbbusy", 32'(ArbBusy), 1);
    ReqValid = 4'b0000;
    repeat (11) @(negedge Clk);
    chk("single_grant_hold", 32'(Grant), 32'h1);
    @(negedge Clk);
    chk("single_grant_clear", 32'(Grant), 0);
    chk("single_arbbusy_clear", 32'(ArbBusy), 0);
    chk("single_txdata_hold", 32'(TxData), 32'hA5);
    chk("single_cycle", cyc - n0, 13);

    // ptr is now 1: with 0 and 1 pending, 1 wins.
    push(4'b0010, 8'hB1);
    run_req("ptr1", 4'b0011, 1);

    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Round robin at minimum spacing.
    tx_busy_len = 1;
    ReqData = {8'h13, 8'h12, 8'h11, 8'h10};
    push(4'b0001, 8'h10);
    push(4'b0010, 8'h11);
    push(4'b0100, 8'h12);
    push(4'b1000, 8'h13);
    push(4'b0001, 8'h10);
    base = n_starts;
    run_req("rr", 4'b1111, 5);
    if (start_cyc.size() >= base + 5) begin
      chk("rr_spacing_first", start_cyc[base+1] - start_cyc[base], 4);
      chk("rr_spacing_wrap", start_cyc[base+4] - start_cyc[base+3], 4);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL rr_spacing: got %0d launches, required 5", start_cyc.size() - base);
    end

    // Wrap and skip: take 2 to set ptr=3, then 0 before 2.
    tx_busy_len = 2;
    ReqData = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    push(4'b0100, 8'hC2);
    run_req("wrap_setup", 4'b0100, 1);
    push(4'b0001, 8'hA0);
    push(4'b0100, 8'hC2);
    run_req("wrap_skip", 4'b0101, 2);

    // Watchdog: transmitter never goes busy.
    tx_busy_len = 0;
    push(4'b0010, 8'hB1);
    n0 = cyc;
    base = n_starts;
    ReqValid = 4'b0010;
    @(negedge Clk);
    ReqValid = 4'b0000;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge Clk);
        if (Timeout === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      chk("wd_timeout_seen", 32'(seen), 1);
    end
    chk("wd_timeout_cycle", cyc - n0, 18);
    chk("wd_grant", 32'(Grant), 0);
    chk("wd_arbbusy", 32'(ArbBusy), 0);
    @(negedge Clk);
    chk("wd_timeout_pulse", 32'(Timeout), 0);
    repeat (10) @(negedge Clk);
    chk("wd_no_relaunch", n_starts - base, 1);

    // Late drop: requester 1 pulses while requester 2 is mid-frame.
    tx_busy_len = 8;
    push(4'b0100, 8'hC2);
    base = n_starts;
    n0 = ack_cnt[1];
    ReqValid = 4'b0100;
    @(negedge Clk);
    ReqValid = 4'b0000;
    repeat (3) @(negedge Clk);
    ReqValid = 4'b0010;
    @(negedge Clk);
    ReqValid = 4'b0000;
    wait_idle("late");
    repeat (6) @(negedge Clk);
    chk("late_no_ack1", ack_cnt[1] - n0, 0);
    chk("late_launches", n_starts - base, 1);

    // Reset mid-frame; ptr is 3 beforehand so requester 3 wins first.
    tx_busy_len = 20;
    ReqData = {8'h13, 8'h12, 8'h11, 8'h10};
    push(4'b1000, 8'h13);
    base = n_starts;
    ReqValid = 4'b1111;
    for (int i = 0; i < 20 && n_starts == base; i++) @(negedge Clk);
    chk("rst_pre_launch", n_starts - base, 1);
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tx_busy_len = 3;
    push(4'b0001, 8'h10);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    rel = cyc;
    @(negedge Clk);
    chk("rst_release_start", 32'(TxStart), 1);
    chk("rst_release_grant", 32'(Grant), 32'h1);
    chk("rst_release_cycle", cyc - rel, 1);
    ReqValid = 4'b0000;
    wait_idle("rst");
    repeat (4) @(negedge Clk);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
